// File: rtl/cam_pkg.sv
// cam_pkg
//   Shared constants and types for the content-addressable register file.
//   Holds the default geometry (entry width, entry count, init pattern base)
//   and the entry data typedef used when the block is built at defaults.
//   No ports: this is a package imported by cam_prio_enc and cam_regfile.
package cam_pkg;

  localparam int DEFAULT_WIDTH     = 4;
  localparam int DEFAULT_DEPTH     = 8;
  localparam int DEFAULT_INIT_BASE = 8;

  typedef logic [DEFAULT_WIDTH-1:0] entry_t;

endpackage : cam_pkg

// File: rtl/cam_prio_enc.sv
// cam_prio_enc
//   Purely combinational two-sided priority encoder over a match vector.
//   Reports the lowest and highest set bit positions and whether any bit is
//   set. With no bit set both indices read 0.
// Ports:
//   match_vec  in   DEPTH   one bit per CAM entry, 1 = entry matched
//   min_idx    out  ADDR_W  index of lowest set bit (0 if none)
//   max_idx    out  ADDR_W  index of highest set bit (0 if none)
//   any_set    out  1       at least one bit of match_vec is set
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  match_vec,
  output logic [ADDR_W-1:0] min_idx,
  output logic [ADDR_W-1:0] max_idx,
  output logic              any_set
);

  // Scanning downward lets the last hit written be the lowest one; scanning
  // upward does the same for the highest.
  always_comb begin
    min_idx = '0;
    max_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i]) min_idx = ADDR_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (match_vec[i]) max_idx = ADDR_W'(i);
    end
  end

  assign any_set = |match_vec;

endmodule : cam_prio_enc

// File: rtl/cam_regfile.sv
// cam_regfile
//   Register file with a parallel content search. Each lookup compares
//   lookup_data against every entry and reports (one cycle later) whether
//   anything matched plus the lowest and highest matching index. A lookup
//   may also rewrite every matching entry with new_data, and a direct
//   single-entry write port is provided. init reloads an incrementing pattern.
//   Build option: define CAM_MATCH_COUNT_EN to add the match_count output.
// Ports:
//   clk           in   1        clock, all state on rising edge
//   init          in   1        synchronous active-high reset / pattern load
//   lookup_valid  in   1        search requested this cycle
//   lookup_data   in   WIDTH    value searched
//   set_en        in   1        replace matching entries (needs lookup_valid)
//   new_data      in   WIDTH    replacement value for set_en
//   wr_en         in   1        direct write enable
//   wr_addr       in   ADDR_W   direct write index
//   wr_data       in   WIDTH    direct write value
//   out_valid     out  1        result below belongs to last cycle's lookup
//   hit           out  1        at least one entry matched
//   min_addr      out  ADDR_W   lowest matching index
//   max_addr      out  ADDR_W   highest matching index
//   match_count   out  ADDR_W+1 number of matches (CAM_MATCH_COUNT_EN only)
module cam_regfile
  import cam_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int INIT_BASE = DEFAULT_INIT_BASE,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              init,
  input  logic              lookup_valid,
  input  logic [WIDTH-1:0]  lookup_data,
  input  logic              set_en,
  input  logic [WIDTH-1:0]  new_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              out_valid,
  output logic              hit,
  output logic [ADDR_W-1:0] min_addr,
  output logic [ADDR_W-1:0] max_addr
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [ADDR_W:0]   match_count
`endif
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  match_vec;
  logic [ADDR_W-1:0] enc_min;
  logic [ADDR_W-1:0] enc_max;
  logic              enc_any;

  // The search uses the contents held before this edge, so the reported
  // result of a set_en lookup always reflects the pre-write values.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = (mem[i] == lookup_data);
    end
  end

  cam_prio_enc #(
    .DEPTH(DEPTH)
  ) u_prio_enc (
    .match_vec(match_vec),
    .min_idx  (enc_min),
    .max_idx  (enc_max),
    .any_set  (enc_any)
  );

  // Entry storage. init wins over everything; otherwise a direct write to an
  // entry beats a set_en replacement of that same entry, while the other
  // matching entries still take new_data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (init) begin
        mem[i] <= WIDTH'(INIT_BASE + i);
      end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
        mem[i] <= wr_data;
      end else if (lookup_valid && set_en && match_vec[i]) begin
        mem[i] <= new_data;
      end
    end
  end

  // Result registers. Outside a valid lookup the result fields hold so a
  // consumer can still read the last answer after out_valid drops.
  always_ff @(posedge clk) begin
    if (init) begin
      out_valid <= 1'b0;
      hit       <= 1'b0;
      min_addr  <= '0;
      max_addr  <= '0;
    end else begin
      out_valid <= lookup_valid;
      if (lookup_valid) begin
        hit      <= enc_any;
        min_addr <= enc_min;
        max_addr <= enc_max;
      end
    end
  end

`ifdef CAM_MATCH_COUNT_EN
  logic [ADDR_W:0] count_next;

  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + (ADDR_W + 1)'(match_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      match_count <= '0;
    end else if (lookup_valid) begin
      match_count <= count_next;
    end
  end
`endif

endmodule : cam_regfile

// File: doc/cam_regfile.md
CAM_REGFILE -- requirements
Module: cam_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 4, entry data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, entry count (power of two, >=2); ADDR_W = log2(DEPTH).
REQ-003 SHALL have parameter INIT_BASE, default 8, base value of the init pattern.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port init  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port lookup_valid  input  1  a lookup is requested this cycle.
REQ-007 SHALL have port lookup_data  input  WIDTH  value searched in parallel across all entries.
REQ-008 SHALL have port set_en  input  1  replace every entry matching lookup_data with new_data; qualified by lookup_valid.
REQ-009 SHALL have port new_data  input  WIDTH  replacement value.
REQ-010 SHALL have port wr_en  input  1  direct write of a single entry.
REQ-011 SHALL have port wr_addr  input  ADDR_W  entry index for the direct write.
REQ-012 SHALL have port wr_data  input  WIDTH  value for the direct write.
REQ-013 SHALL have port out_valid  output  1  lookup result valid this cycle.
REQ-014 SHALL have port hit  output  1  at least one entry matched.
REQ-015 SHALL have port min_addr  output  ADDR_W  lowest matching index.
REQ-016 SHALL have port max_addr  output  ADDR_W  highest matching index.

Function
REQ-017 SHALL compare lookup_data against all DEPTH entries within one cycle, using contents as held before the current edge.
REQ-018 SHALL register results: out_valid/hit/min_addr/max_addr reflect the lookup presented in cycle N during cycle N+1 (latency 1), and support back-to-back lookups at one per cycle.
REQ-019 SHALL drive out_valid=0 in any cycle following a cycle with lookup_valid=0; hit/min_addr/max_addr then hold their last values.
REQ-020 SHALL drive hit=0, min_addr=0, max_addr=0 on a valid lookup with no match.
REQ-021 SHALL, when lookup_valid=1 and set_en=1, write new_data at the edge into every entry that matched; the result reported for that lookup uses the pre-write contents.
REQ-022 SHALL ignore set_en when lookup_valid=0.
REQ-023 SHALL, when wr_en=1, write wr_data into entry wr_addr at the edge.
REQ-024 SHALL give wr_en priority over set_en when both target the same entry in the same cycle; other matching entries still take new_data.
REQ-025 SHALL allow new_data equal to lookup_data (no functional change, no error).

Reset
REQ-026 SHALL, on init=1 at an edge, load entry i with (INIT_BASE + i) mod 2^WIDTH and clear out_valid, hit, min_addr, max_addr (and match_count) to 0.
REQ-027 SHALL give init priority over wr_en, set_en and lookup_valid; a lookup presented in the init cycle produces no result (out_valid=0 next cycle).

Configuration
REQ-028 SHALL, with CAM_MATCH_COUNT_EN defined, add output match_count (ADDR_W+1 bits), the number of matching entries, registered with the same latency as hit and 0 on no match.
REQ-029 SHALL, without CAM_MATCH_COUNT_EN, omit the match_count port and its logic entirely.

Structure
REQ-030 SHALL place default WIDTH/DEPTH/INIT_BASE constants and the entry data typedef in shared package cam_pkg.
REQ-031 SHALL implement min/max index extraction from the DEPTH-bit match vector in sub-module cam_prio_enc (outputs lowest index, highest index, any-set).

Verification (WIDTH=4, DEPTH=8, INIT_BASE=8)
REQ-032 SHALL test: init then lookup 4'hA -> next cycle out_valid=1, hit=1, min_addr=2, max_addr=2 (match_count=1).
REQ-033 SHALL test: lookup 4'hA with set_en, new_data=4'hC -> that result min=max=2; next lookup 4'hC -> min_addr=2, max_addr=4, match_count=2.
REQ-034 SHALL test: lookup 4'h3 on init contents -> hit=0, min_addr=0, max_addr=0, out_valid=1.
REQ-035 SHALL test: wr_en addr 7 data 4'hC, then lookup 4'hC -> min_addr=2, max_addr=7, match_count=3.
REQ-036 SHALL test: same cycle wr_en addr 2 data 4'h1 plus set_en lookup 4'hC new 4'h5 -> entry2=1, entries 4 and 7 =5; lookup 4'h5 -> min_addr=4, max_addr=7.
REQ-037 SHALL test: init asserted with lookup_valid=1 -> next cycle out_valid=0; lookup 4'hF -> min_addr=max_addr=7.
